cellrv32_cpu_cp_fpu16_i2h: RTL

CELLRV32_CPU_CP_FPU16_I2H -- requirements
Module: cellrv32_cpu_cp_fpu16_i2h

---
 rtl/cellrv32_package.sv | 26 ++
 rtl/cellrv32_cpu_cp_fpu16_lzc.sv | 15 +
 rtl/cellrv32_cpu_cp_fpu16_i2h.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/cellrv32_package.sv
// Shared binary16 constants, rounding-mode encodings and exception flag indices.
package cellrv32_package;

  localparam int unsigned fp16_bias_c    = 15;
  localparam logic [15:0] fp16_pos_inf_c = 16'h7C00;
  localparam logic [15:0] fp16_max_c     = 16'h7BFF;

  localparam logic [2:0] fp_rm_rne_c = 3'b000;
  localparam logic [2:0] fp_rm_rtz_c = 3'b001;
  localparam logic [2:0] fp_rm_rdn_c = 3'b010;
  localparam logic [2:0] fp_rm_rup_c = 3'b011;
  localparam logic [2:0] fp_rm_rmm_c = 3'b100;

  localparam int unsigned fp_exc_nx_c = 0;
  localparam int unsigned fp_exc_uf_c = 1;
  localparam int unsigned fp_exc_of_c = 2;
  localparam int unsigned fp_exc_dz_c = 3;
  localparam int unsigned fp_exc_nv_c = 4;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] man;
  } fp16_t;

endpackage

// File: rtl/cellrv32_cpu_cp_fpu16_lzc.sv
// 32-bit leading-zero counter; an all-zero input reports 32.
module cellrv32_cpu_cp_fpu16_lzc (
  input  logic [31:0] data_i,
  output logic [5:0]  zeros_c
);

  // ascending scan so the highest set bit wins
  always_comb begin
    zeros_c = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (data_i[i]) zeros_c = 6'(31 - i);
    end
  end

endmodule

// File: rtl/cellrv32_cpu_cp_fpu16_i2h.sv
// Integer (signed/unsigned 32-bit) to binary16 converter, multi-cycle FSM.
// CELLRV32_FPU16_I2H_FAST_NORM_EN selects a single-cycle LZC/barrel normalizer.
module cellrv32_cpu_cp_fpu16_i2h
  import cellrv32_package::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            start_i,
  input  logic [2:0]      rmode_i,
  input  logic            funct_i,
  input  logic [XLEN-1:0] data_i,
  output logic [15:0]     result_o,
  output logic [4:0]      flags_o,
  output logic            done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREPARE,
    S_NORMALIZE,
    S_ROUND,
    S_FINALIZE
  } state_t;

  state_t state_q, state_d;

  logic [31:0] op_q, op_d;
  logic        uns_q, uns_d;
  logic [2:0]  rm_q, rm_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [5:0]  exp_q, exp_d;
  logic [9:0]  man_q, man_d;
  logic        nx_q, nx_d;
  logic        zero_q, zero_d;
  logic [15:0] result_d;
  logic [4:0]  flags_d;
  logic        done_d;

  logic        prep_sign;
  logic [31:0] prep_mag;
  logic        rnd_g, rnd_r, rnd_s, rnd_inc;
  logic [10:0] man_sum;
  logic        ovf;
  fp16_t       fin;
  logic [15:0] ovf_res;

  assign prep_sign = ~uns_q & op_q[31];
  assign prep_mag  = prep_sign ? (~op_q + 32'd1) : op_q;

`ifdef CELLRV32_FPU16_I2H_FAST_NORM_EN
  logic [5:0] lz_c;

  cellrv32_cpu_cp_fpu16_lzc u_lzc (
    .data_i  (mag_q),
    .zeros_c (lz_c)
  );
`endif

  // rounding increment from guard/round/sticky below the 10-bit mantissa
  always_comb begin
    rnd_g   = mag_q[20];
    rnd_r   = mag_q[19];
    rnd_s   = |mag_q[18:0];
    rnd_inc = 1'b0;
    case (rm_q)
      fp_rm_rne_c: rnd_inc = rnd_g & (rnd_r | rnd_s | mag_q[21]);
      fp_rm_rtz_c: rnd_inc = 1'b0;
      fp_rm_rdn_c: rnd_inc = sign_q & (rnd_g | rnd_r | rnd_s);
      fp_rm_rup_c: rnd_inc = ~sign_q & (rnd_g | rnd_r | rnd_s);
      fp_rm_rmm_c: rnd_inc = rnd_g;
      default:     rnd_inc = 1'b0;
    endcase
    man_sum = {1'b0, mag_q[30:21]} + 11'(rnd_inc);
  end

  // packed result and overflow substitute (inf or max depending on direction)
  always_comb begin
    ovf      = exp_q > 6'(fp16_bias_c);
    fin.sign = sign_q;
    fin.exp  = 5'(exp_q + 6'(fp16_bias_c));
    fin.man  = man_q;
    ovf_res  = fp16_pos_inf_c;
    case (rm_q)
      fp_rm_rtz_c: ovf_res = fp16_max_c;
      fp_rm_rdn_c: ovf_res = sign_q ? fp16_pos_inf_c : fp16_max_c;
      fp_rm_rup_c: ovf_res = sign_q ? fp16_max_c : fp16_pos_inf_c;
      default:     ovf_res = fp16_pos_inf_c;
    endcase
    ovf_res[15] = sign_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start_i) state_d = S_PREPARE;
      S_PREPARE:   state_d = (prep_mag == 32'd0) ? S_FINALIZE : S_NORMALIZE;
`ifdef CELLRV32_FPU16_I2H_FAST_NORM_EN
      S_NORMALIZE: state_d = S_ROUND;
`else
      S_NORMALIZE: if (mag_q[31]) state_d = S_ROUND;
`endif
      S_ROUND:     state_d = S_FINALIZE;
      S_FINALIZE:  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // datapath and registered-output next values
  always_comb begin
    op_d     = op_q;
    uns_d    = uns_q;
    rm_d     = rm_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    man_d    = man_q;
    nx_d     = nx_q;
    zero_d   = zero_q;
    result_d = result_o;
    flags_d  = flags_o;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d  = 32'(data_i);
          uns_d = funct_i;
          rm_d  = rmode_i;
        end
      end
      S_PREPARE: begin
        sign_d = prep_sign;
        mag_d  = prep_mag;
        exp_d  = 6'd31;
        zero_d = (prep_mag == 32'd0);
      end
      S_NORMALIZE: begin
`ifdef CELLRV32_FPU16_I2H_FAST_NORM_EN
        mag_d = mag_q << lz_c;
        exp_d = exp_q - lz_c;
`else
        if (!mag_q[31]) begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 6'd1;
        end
`endif
      end
      S_ROUND: begin
        nx_d = rnd_g | rnd_r | rnd_s;
        if (man_sum[10]) begin
          man_d = 10'd0;
          exp_d = exp_q + 6'd1;
        end else begin
          man_d = man_sum[9:0];
        end
      end
      S_FINALIZE: begin
        done_d  = 1'b1;
        flags_d = 5'd0;
        if (zero_q) begin
          result_d = 16'h0000;
        end else if (!ovf) begin
          result_d             = fin;
          flags_d[fp_exc_nx_c] = nx_q;
        end else begin
          result_d             = ovf_res;
          flags_d[fp_exc_nx_c] = 1'b1;
          flags_d[fp_exc_of_c] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      op_q     <= 32'd0;
      uns_q    <= 1'b0;
      rm_q     <= 3'd0;
      sign_q   <= 1'b0;
      mag_q    <= 32'd0;
      exp_q    <= 6'd0;
      man_q    <= 10'd0;
      nx_q     <= 1'b0;
      zero_q   <= 1'b0;
      result_o <= 16'h0000;
      flags_o  <= 5'd0;
      done_o   <= 1'b0;
    end else begin
      op_q     <= op_d;
      uns_q    <= uns_d;
      rm_q     <= rm_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      man_q    <= man_d;
      nx_q     <= nx_d;
      zero_q   <= zero_d;
      result_o <= result_d;
      flags_o  <= flags_d;
      done_o   <= done_d;
    end
  end

endmodule
